red_pitaya_iq_modulator_block: RTL

Transmit-side counterpart of the IQ demodulator. It takes two baseband quadratures, scales each by a signed gain, and mixes them onto the fgen sin/cos. It then sums the two products, applies a ramped amplitude envelope and a DC offset, and saturates to DAC width. It sits between the IQ filter/gain chain and the output DSP mux. A small FSM soft-starts and soft-stops the carrier on enable.

---
 rtl/red_pitaya_iq_modulator_block_pkg.sv | 37 +++
 rtl/red_pitaya_round_sat.sv | 64 ++++++
 rtl/red_pitaya_iq_modulator_block.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_iq_modulator_block_pkg.sv
`default_nettype none
// ============================================================================
//  red_pitaya_iq_modulator_block_pkg
//  Shared FSM encoding, default widths and stage-width helpers for the
//  IQ modulator.
//  Revision: 1.0
// ============================================================================
package red_pitaya_iq_modulator_block_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } iqmod_state_t;

    localparam int IQMOD_LATENCY  = 5;

    localparam int IQMOD_INBITS   = 18;
    localparam int IQMOD_GAINBITS = 16;
    localparam int IQMOD_SINBITS  = 14;
    localparam int IQMOD_OUTBITS  = 14;
    localparam int IQMOD_RAMPBITS = 16;

    // Right shift that brings the summed mixer products down to OUTBITS+2.
    function automatic int iqmod_mix_shift(input int inbits, input int sinbits,
                                           input int outbits);
        return sinbits - 1 + inbits - outbits;
    endfunction

    // Gain product is scaled so that 2**(GAINBITS-2) means unity.
    function automatic int iqmod_gain_shift(input int gainbits);
        return gainbits - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_round_sat.sv
`default_nettype none
// ============================================================================
//  red_pitaya_round_sat
//  Combinational symmetric round-half-toward-zero shift followed by a
//  symmetric clamp to +/-(2**(OUT_W-1)-1).
//  Revision: 1.0
// ============================================================================
module red_pitaya_round_sat #(
    parameter int IN_W  = 34,
    parameter int SHIFT = 14,
    parameter int OUT_W = 18
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_sat
);

    localparam int EXT_W  = IN_W + 1;
    localparam int WIDE_W = ((EXT_W > OUT_W) ? EXT_W : OUT_W) + 1;

    localparam logic signed [WIDE_W-1:0] c_max =
        {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] c_min = -c_max;

    logic signed [EXT_W-1:0]  w_ext;
    logic signed [EXT_W-1:0]  w_shr;
    logic signed [WIDE_W-1:0] w_wide;

    assign w_ext = {i_val[IN_W-1], i_val};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] c_half =
                {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT-1);
            localparam logic signed [EXT_W-1:0] c_half_m1 = c_half - EXT_W'(1);

            logic signed [EXT_W-1:0] w_bias;
            logic signed [EXT_W-1:0] w_sum;

            // Negative values get the full half so ties fall toward zero.
            assign w_bias = i_val[IN_W-1] ? c_half : c_half_m1;
            assign w_sum  = w_ext + w_bias;
            assign w_shr  = w_sum >>> SHIFT;
        end else begin : g_pass
            assign w_shr = w_ext;
        end
    endgenerate

    assign w_wide = WIDE_W'(w_shr);

    always_comb begin
        o_sat = 1'b0;
        o_val = w_wide[OUT_W-1:0];
        if (w_wide > c_max) begin
            o_sat = 1'b1;
            o_val = c_max[OUT_W-1:0];
        end else if (w_wide < c_min) begin
            o_sat = 1'b1;
            o_val = c_min[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/red_pitaya_iq_modulator_block.sv
`default_nettype none
// ============================================================================
//  red_pitaya_iq_modulator_block
//  Gain-scales two quadratures, mixes them onto sin/cos, applies a soft
//  start/stop envelope plus DC offset and saturates to DAC width.
//  Revision: 1.0
// ============================================================================
module red_pitaya_iq_modulator_block
    import red_pitaya_iq_modulator_block_pkg::*;
#(
    parameter int INBITS   = IQMOD_INBITS,
    parameter int GAINBITS = IQMOD_GAINBITS,
    parameter int SINBITS  = IQMOD_SINBITS,
    parameter int OUTBITS  = IQMOD_OUTBITS,
    parameter int RAMPBITS = IQMOD_RAMPBITS
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic signed [SINBITS-1:0]  sin,
    input  logic signed [SINBITS-1:0]  cos,
    input  logic signed [INBITS-1:0]   signal1_i,
    input  logic signed [INBITS-1:0]   signal2_i,
    input  logic signed [GAINBITS-1:0] g1_i,
    input  logic signed [GAINBITS-1:0] g2_i,
    input  logic signed [OUTBITS-1:0]  offset_i,
    input  logic                       enable_i,
    input  logic [RAMPBITS-1:0]        ramp_step_i,
    output logic signed [OUTBITS-1:0]  dat_o,
    output logic                       active_o,
    output logic                       sat_o
);

    localparam int PROD_W    = INBITS + GAINBITS;
    localparam int MIX_W     = INBITS + SINBITS;
    localparam int SUM_W     = MIX_W + 1;
    localparam int S_W       = OUTBITS + 2;
    localparam int AMP_W     = RAMPBITS + 1;
    localparam int ENV_W     = S_W + AMP_W + 1;
    localparam int E_W       = S_W + 1;
    localparam int OSUM_W    = ((E_W > OUTBITS) ? E_W : OUTBITS) + 1;
    localparam int SAT_DLY   = IQMOD_LATENCY - 2;
    localparam int GAIN_SH   = iqmod_gain_shift(GAINBITS);
    localparam int MIX_SH    = iqmod_mix_shift(INBITS, SINBITS, OUTBITS);

    localparam logic [AMP_W-1:0] c_unity = {1'b1, {RAMPBITS{1'b0}}};

    // ------------------------------------------------------------------
    // Datapath signals
    // ------------------------------------------------------------------
    logic signed [SINBITS-1:0] r_sin_d1, r_sin_d2;
    logic signed [SINBITS-1:0] r_cos_d1, r_cos_d2;
    logic signed [PROD_W-1:0]  r_p1, r_p2;
    logic signed [INBITS-1:0]  w_q1, w_q2;
    logic                      w_q1_sat, w_q2_sat;
    logic signed [INBITS-1:0]  r_q1, r_q2;
    logic signed [MIX_W-1:0]   r_m1, r_m2;
    logic signed [SUM_W-1:0]   w_msum;
    logic signed [S_W-1:0]     w_s;
    logic                      w_s_sat;
    logic signed [S_W-1:0]     r_s;
    logic signed [ENV_W-1:0]   w_env;
    logic signed [E_W-1:0]     w_e;
    logic                      w_e_sat;
    logic signed [OSUM_W-1:0]  w_osum;
    logic signed [OUTBITS-1:0] w_out;
    logic                      w_out_sat;
    logic [SAT_DLY-1:0]        r_sat_pipe;
    logic signed [OUTBITS-1:0] r_dat;
    logic                      r_sat;

    // ------------------------------------------------------------------
    // Envelope FSM signals
    // ------------------------------------------------------------------
    iqmod_state_t              r_state;
    logic [AMP_W-1:0]          r_amp;
    logic                      r_active;
    logic [AMP_W-1:0]          w_step_ext;
    logic [AMP_W:0]            w_up_sum;
    logic                      w_step_zero;
    logic                      w_up_full;
    logic                      w_dn_empty;
    logic [AMP_W-1:0]          w_dn_amp;

    // ------------------------------------------------------------------
    // S2 rounding/saturation of the gain products
    // ------------------------------------------------------------------
    red_pitaya_round_sat #(
        .IN_W  (PROD_W),
        .SHIFT (GAIN_SH),
        .OUT_W (INBITS)
    ) u_rs_q1 (
        .i_val (r_p1),
        .o_val (w_q1),
        .o_sat (w_q1_sat)
    );

    red_pitaya_round_sat #(
        .IN_W  (PROD_W),
        .SHIFT (GAIN_SH),
        .OUT_W (INBITS)
    ) u_rs_q2 (
        .i_val (r_p2),
        .o_val (w_q2),
        .o_sat (w_q2_sat)
    );

    // ------------------------------------------------------------------
    // S4 mixer sum; OUTBITS+2 holds the worst case so it never clamps
    // ------------------------------------------------------------------
    assign w_msum = SUM_W'(r_m1) + SUM_W'(r_m2);

    red_pitaya_round_sat #(
        .IN_W  (SUM_W),
        .SHIFT (MIX_SH),
        .OUT_W (S_W)
    ) u_rs_s (
        .i_val (w_msum),
        .o_val (w_s),
        .o_sat (w_s_sat)
    );

    // ------------------------------------------------------------------
    // S5 envelope, offset and final clamp
    // ------------------------------------------------------------------
    assign w_env = ENV_W'(r_s) * ENV_W'($signed({1'b0, r_amp}));

    red_pitaya_round_sat #(
        .IN_W  (ENV_W),
        .SHIFT (RAMPBITS),
        .OUT_W (E_W)
    ) u_rs_env (
        .i_val (w_env),
        .o_val (w_e),
        .o_sat (w_e_sat)
    );

    assign w_osum = OSUM_W'(w_e) + OSUM_W'(offset_i);

    red_pitaya_round_sat #(
        .IN_W  (OSUM_W),
        .SHIFT (0),
        .OUT_W (OUTBITS)
    ) u_rs_out (
        .i_val (w_osum),
        .o_val (w_out),
        .o_sat (w_out_sat)
    );

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sin_d1   <= '0;
            r_sin_d2   <= '0;
            r_cos_d1   <= '0;
            r_cos_d2   <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_q1       <= '0;
            r_q2       <= '0;
            r_m1       <= '0;
            r_m2       <= '0;
            r_s        <= '0;
            r_sat_pipe <= '0;
            r_dat      <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_sin_d1   <= sin;
            r_sin_d2   <= r_sin_d1;
            r_cos_d1   <= cos;
            r_cos_d2   <= r_cos_d1;
            r_p1       <= PROD_W'(signal1_i) * PROD_W'(g1_i);
            r_p2       <= PROD_W'(signal2_i) * PROD_W'(g2_i);
            r_q1       <= w_q1;
            r_q2       <= w_q2;
            r_m1       <= MIX_W'(r_q1) * MIX_W'(r_sin_d2);
            r_m2       <= MIX_W'(r_q2) * MIX_W'(r_cos_d2);
            r_s        <= w_s;
            // Input-stage clamp flag travels alongside its sample to S5.
            r_sat_pipe <= {r_sat_pipe[SAT_DLY-2] | w_s_sat,
                           r_sat_pipe[SAT_DLY-3:0],
                           w_q1_sat | w_q2_sat};
            r_dat      <= w_out;
            r_sat      <= w_out_sat | w_e_sat | r_sat_pipe[SAT_DLY-1];
        end
    end

    // ------------------------------------------------------------------
    // Envelope FSM
    // ------------------------------------------------------------------
    assign w_step_ext  = {1'b0, ramp_step_i};
    assign w_step_zero = (ramp_step_i == '0);
    assign w_up_sum    = {1'b0, r_amp} + {2'b00, ramp_step_i};
    assign w_up_full   = w_step_zero || (w_up_sum >= {1'b0, c_unity});
    assign w_dn_empty  = w_step_zero || (r_amp <= w_step_ext);
    assign w_dn_amp    = r_amp - w_step_ext;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= ST_OFF;
            r_amp    <= '0;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (enable_i && w_step_zero) begin
                        r_state  <= ST_ON;
                        r_amp    <= c_unity;
                        r_active <= 1'b1;
                    end else if (enable_i) begin
                        r_state  <= ST_RAMP_UP;
                        r_amp    <= w_step_ext;
                        r_active <= 1'b1;
                    end else begin
                        r_amp    <= '0;
                        r_active <= 1'b0;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (enable_i && w_up_full) begin
                        r_state  <= ST_ON;
                        r_amp    <= c_unity;
                        r_active <= 1'b1;
                    end else if (enable_i) begin
                        r_state  <= ST_RAMP_UP;
                        r_amp    <= w_up_sum[AMP_W-1:0];
                        r_active <= 1'b1;
                    end else if (w_dn_empty) begin
                        r_state  <= ST_OFF;
                        r_amp    <= '0;
                        r_active <= 1'b0;
                    end else begin
                        r_state  <= ST_RAMP_DOWN;
                        r_amp    <= w_dn_amp;
                        r_active <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (enable_i) begin
                        r_amp    <= c_unity;
                        r_active <= 1'b1;
                    end else if (w_dn_empty) begin
                        r_state  <= ST_OFF;
                        r_amp    <= '0;
                        r_active <= 1'b0;
                    end else begin
                        r_state  <= ST_RAMP_DOWN;
                        r_amp    <= w_dn_amp;
                        r_active <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_OFF;
                    r_amp    <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign dat_o    = r_dat;
    assign sat_o    = r_sat;
    assign active_o = r_active;

endmodule
`default_nettype wire
